life_row_engine: RTL and testbench
==================================

Name: life_row_engine

Overview:
- Streaming, parametrised Game-of-Life generation engine. Replaces per-cell combinational neighbour checks.
- Accepts a frame one row per cycle (WIDTH cells per row) over a valid/ready handshake.
- Buffers a sliding three-row window and emits the next-generation rows over a second valid/ready handshake.
- The birth/survive rule is set by parameter masks. Sits between the frame store read port and its write-back port.

Parameters:
WIDTH, 8, cells per row; bit i = column i; legal range 3..256
WRAP, 0, 0 = cells beyond column 0 / WIDTH-1 are dead; 1 = horizontal wrap-around (vertical edges are always dead)
BIRTH_MASK, 9'b000001000, bit n set = dead cell with n live neighbours becomes alive (default B3)
SURVIVE_MASK, 9'b000001100, bit n set = live cell with n live neighbours stays alive (default S23)
FCNT_W, 16, width of the frame counter

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_row/in_last valid
in_ready  out  1  engine accepts a row this cycle
in_row  in  WIDTH  current-generation row
in_last  in  1  marks the final row of the frame
out_valid  out  1  out_row/out_last valid
out_ready  in  1  downstream accepts the output row
out_row  out  WIDTH  next-generation row
out_last  out  1  marks the final output row of the frame
frame_count  out  FCNT_W  number of completed output frames

Behaviour:
- Reset (rst=1 at a clock edge) forces the following, regardless of other inputs, including mid-frame:
  - state=IDLE; prev=0, cur=0
  - out_valid=0, out_row=0, out_last=0, frame_count=0
  - Any partial frame is discarded.
- Handshake:
  - Transfer occurs when valid && ready at a rising edge.
  - out_valid/out_row/out_last hold stable until out_ready=1.
  - The output slot is "free" when out_valid=0 or out_ready=1.
  - in_ready = slot free && state!=FLUSH. This is combinational from out_valid, out_ready and state; it never depends on in_valid.
- Next-gen function: next(p,c,n) per column i.
  - Neighbour count k (4 bits, 0..8) = sum of p[i-1],p[i],p[i+1],c[i-1],c[i+1],n[i-1],n[i],n[i+1].
  - Out-of-range columns read 0 (WRAP=0) or index modulo WIDTH (WRAP=1).
  - Result = c[i] ? SURVIVE_MASK[k] : BIRTH_MASK[k].
- States:
  - IDLE: on input transfer, prev<=0, cur<=in_row, no output. Go to FLUSH if in_last, else HOLD.
  - HOLD: on input transfer, the output slot loads out_row=next(prev,cur,in_row), out_last=0, out_valid=1; then prev<=cur, cur<=in_row. Go to FLUSH if in_last, else stay in HOLD.
  - FLUSH: no input accepted. When the slot is free, load out_row=next(prev,cur,0), out_last=1, out_valid=1. Go to IDLE; frame_count increments on that same edge, wrapping at 2^FCNT_W.
- If the slot is free and nothing is loaded, out_valid<=0 at that edge.
- Latency:
  - Output row r appears the cycle after input row r+1 is accepted.
  - The final row appears the cycle after entering FLUSH with the slot free.
  - Full throughput is one row per cycle with out_ready held at 1. FLUSH costs one input bubble per frame.
- A single-row frame (in_last on the first row) yields exactly one output row: next(0,row,0) with out_last=1.
- Vertical edges: the row above the first row and the row below the last row are dead.

Test Plan:
1. WIDTH=8, WRAP=0, defaults. Frame 00,1C,00 (last on third row) -> outputs 08,08,08; out_last on third output only; frame_count=1.
2. Still life: frame 00,18,18,00 -> outputs 00,18,18,00. Then an immediate second frame 00,1C,00 -> 08,08,08; frame_count=2.
3. Single-row frame FF with in_last: WRAP=0 -> 7E, out_last=1. Same stimulus with WRAP=1 -> FF.
4. Backpressure: stream frame 1 with out_ready=0 for 5 cycles after the first output:
   - out_row and out_last stay stable and in_ready=0 throughout.
   - On release, the remaining rows are delivered in order with none lost or duplicated.
5. Reset mid-frame after 2 of 4 rows, with out_valid=1: the next cycle has out_valid=0, in_ready=1, frame_count=0. A fresh frame 00,1C,00 then yields 08,08,08.
6. HighLife (BIRTH_MASK=9'b001001000): a row containing six live neighbours around a dead cell is born. Compare against the golden software model on 200 random frames, including random in_valid/out_ready gaps.

Source files
------------

// File: rtl/life_row_engine.sv
// life_row_engine: streaming Game-of-Life generation engine.
// Takes a frame one row per cycle, keeps a three-row sliding window
// (prev, cur, incoming) and emits next-generation rows one cycle after
// the row below them arrives. The last row is produced from a dead row
// below it while the engine sits in FLUSH.
module life_row_engine #(
  parameter int         WIDTH        = 8,
  parameter bit         WRAP         = 1'b0,
  parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100,
  parameter int         FCNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_row,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_row,
  output logic              out_last,
  output logic [FCNT_W-1:0] frame_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_prev;
  logic [WIDTH-1:0]   r_cur;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_row;
  logic               r_out_last;
  logic [FCNT_W-1:0]  r_frame_count;

  logic               w_slot_free;
  logic               w_in_fire;
  logic               w_load;
  logic               w_load_last;
  logic [WIDTH-1:0]   w_below;
  logic [WIDTH-1:0]   w_gen;
  logic [WIDTH+1:0]   w_p_ext;
  logic [WIDTH+1:0]   w_c_ext;
  logic [WIDTH+1:0]   w_n_ext;

  // Handshake: output slot can take a new row when empty or draining now.
  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = w_slot_free && (r_state != S_FLUSH);
  assign w_in_fire   = in_valid && in_ready;

  // The row below the centre row is the incoming row only while streaming;
  // in FLUSH it is the dead row past the bottom edge.
  assign w_below = (r_state == S_HOLD) ? in_row : '0;

  // Rows extended by one column on each side: ext[j+1] is column j,
  // ext[0] is column -1 and ext[WIDTH+1] is column WIDTH.
  assign w_p_ext = {(WRAP ? r_prev[0]  : 1'b0), r_prev,  (WRAP ? r_prev[WIDTH-1]  : 1'b0)};
  assign w_c_ext = {(WRAP ? r_cur[0]   : 1'b0), r_cur,   (WRAP ? r_cur[WIDTH-1]   : 1'b0)};
  assign w_n_ext = {(WRAP ? w_below[0] : 1'b0), w_below, (WRAP ? w_below[WIDTH-1] : 1'b0)};

  // Per-column neighbour count and birth/survive rule lookup.
  for (genvar i = 0; i < WIDTH; i++) begin : g_col
    logic [3:0] w_k;
    assign w_k = 4'(w_p_ext[i]) + 4'(w_p_ext[i+1]) + 4'(w_p_ext[i+2])
               + 4'(w_c_ext[i])                     + 4'(w_c_ext[i+2])
               + 4'(w_n_ext[i]) + 4'(w_n_ext[i+1]) + 4'(w_n_ext[i+2]);
    assign w_gen[i] = r_cur[i] ? SURVIVE_MASK[w_k] : BIRTH_MASK[w_k];
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and output-slot load decisions.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_last = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_in_fire) w_state_nxt = in_last ? S_FLUSH : S_HOLD;
      end
      S_HOLD: begin
        if (w_in_fire) begin
          w_load      = 1'b1;
          w_state_nxt = in_last ? S_FLUSH : S_HOLD;
        end
      end
      S_FLUSH: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_load_last = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Row window: shift on every accepted row; the first row of a frame
  // has a dead row above it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_cur  <= '0;
    end else if (w_in_fire) begin
      r_prev <= (r_state == S_IDLE) ? '0 : r_cur;
      r_cur  <= in_row;
    end
  end

  // Output slot and completed-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_row     <= '0;
      r_out_last    <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_row   <= w_gen;
        r_out_last  <= w_load_last;
      end else if (w_slot_free) begin
        r_out_valid <= 1'b0;
      end
      if (w_load_last) r_frame_count <= r_frame_count + 1'b1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_row     = r_out_row;
  assign out_last    = r_out_last;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_life_row_engine.sv
// Bench for life_row_engine. Three instances share one input stream:
//   u0: WRAP=0, B3/S23       u1: WRAP=1, B3/S23
//   u2: WRAP=0, B36/S23 (HighLife), 3-bit frame counter
// Handshake timing does not depend on cell data, so all three move in
// lockstep; u0's in_ready paces the driver. Expected rows go into one
// queue per instance; the monitor pops and compares on each output transfer.
module tb_life_row_engine;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_row;
  logic         in_last;
  logic         out_ready;

  logic         in_ready0, in_ready1, in_ready2;
  logic         out_valid0, out_valid1, out_valid2;
  logic [W-1:0] out_row0, out_row1, out_row2;
  logic         out_last0, out_last1, out_last2;
  logic [15:0]  fc0, fc1;
  logic [2:0]   fc2;

  always #5 clk = ~clk;

  life_row_engine #(.WIDTH(W), .WRAP(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_row(in_row), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_row(out_row0), .out_last(out_last0),
    .frame_count(fc0));

  life_row_engine #(.WIDTH(W), .WRAP(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_row(in_row), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_row(out_row1), .out_last(out_last1),
    .frame_count(fc1));

  life_row_engine #(.WIDTH(W), .WRAP(1'b0), .BIRTH_MASK(9'b001001000),
                    .FCNT_W(3)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_row(in_row), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_row(out_row2), .out_last(out_last2),
    .frame_count(fc2));

  // Configurations of the three instances, as seen by the reference model.
  bit         cfg_wrap [3] = '{1'b0, 1'b1, 1'b0};
  logic [8:0] cfg_bm   [3] = '{9'h008, 9'h008, 9'h048};
  logic [8:0] cfg_sm   [3] = '{9'h00C, 9'h00C, 9'h00C};

  // {out_valid, out_last, out_row} per instance.
  logic [9:0] act [3];
  assign act[0] = {out_valid0, out_last0, out_row0};
  assign act[1] = {out_valid1, out_last1, out_row1};
  assign act[2] = {out_valid2, out_last2, out_row2};

  // Expected {last, row} per instance.
  logic [8:0] exp_q [3][$];

  int n_vec  = 0;
  int n_fail = 0;
  int exp_frames = 0;

  // out_ready source selection.
  typedef enum logic [1:0] {RDY_ALWAYS, RDY_RANDOM, RDY_MANUAL} rdy_mode_t;
  rdy_mode_t rdy_mode = RDY_ALWAYS;
  logic      rnd_ready = 1'b1;
  logic      man_ready = 1'b1;
  assign out_ready = (rdy_mode == RDY_ALWAYS) ? 1'b1 :
                     (rdy_mode == RDY_RANDOM) ? rnd_ready : man_ready;

  always @(posedge clk) begin
    #1 rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: a cell of the frame, dead outside the frame vertically,
  // dead or wrapped horizontally.
  function automatic logic model_cell(input logic [7:0] rows[$], input int r,
                                      input int c, input bit wrap);
    logic [7:0] v;
    int cc;
    if (r < 0 || r >= rows.size()) return 1'b0;
    cc = c;
    if (cc < 0 || cc >= W) begin
      if (!wrap) return 1'b0;
      cc = (cc + W) % W;
    end
    v = rows[r];
    return v[cc[2:0]];
  endfunction

  // Whole-frame next generation for instance d, pushed to its queue.
  task automatic push_model(input int d, input logic [7:0] rows[$]);
    for (int r = 0; r < rows.size(); r++) begin
      logic [7:0] nxt;
      for (int c = 0; c < W; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              n += int'(model_cell(rows, r + dr, c + dc, cfg_wrap[d]));
        nxt[c] = model_cell(rows, r, c, cfg_wrap[d]) ? cfg_sm[d][n] : cfg_bm[d][n];
      end
      exp_q[d].push_back({(r == rows.size() - 1), nxt});
    end
  endtask

  task automatic push_list(input int d, input logic [7:0] exp_rows[$]);
    for (int r = 0; r < exp_rows.size(); r++)
      exp_q[d].push_back({(r == exp_rows.size() - 1), exp_rows[r]});
  endtask

  // Drive one row and hold it until accepted (bounded).
  task automatic drive_row(input logic [7:0] row, input logic last);
    int  budget;
    bit  rdy;
    budget = 0;
    in_valid = 1'b1;
    in_row   = row;
    in_last  = last;
    do begin
      @(negedge clk);
      rdy = in_ready0;
      @(posedge clk);
      #1;
      budget++;
    end while (!rdy && budget < 2000);
    if (!rdy) check("input_accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Issue a frame: expectations from the listed constants where given,
  // otherwise from the reference model; then stream its rows.
  task automatic run_frame(input logic [7:0] rows[$], input logic [7:0] ov0[$],
                           input logic [7:0] ov1[$], input logic [7:0] ov2[$],
                           input int gap_max);
    if (ov0.size() > 0) push_list(0, ov0); else push_model(0, rows);
    if (ov1.size() > 0) push_list(1, ov1); else push_model(1, rows);
    if (ov2.size() > 0) push_list(2, ov2); else push_model(2, rows);
    exp_frames++;
    for (int r = 0; r < rows.size(); r++) begin
      int gap;
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      drive_row(rows[r], (r == rows.size() - 1));
    end
  endtask

  task automatic drain_and_count(input string tag);
    int budget;
    budget = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && budget < 5000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check({tag, "_pending_rows"}, exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_frame_count_u0"}, fc0, exp_frames % 65536);
    check({tag, "_frame_count_u1"}, fc1, exp_frames % 65536);
    check({tag, "_frame_count_u2"}, fc2, exp_frames % 8);
  endtask

  // Monitor: on each output transfer, pop and compare per instance.
  always @(negedge clk) begin
    if (!rst && out_valid0 && out_ready) begin
      for (int d = 0; d < 3; d++) begin
        if (exp_q[d].size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_out_u%0d: got %0h expected none", d, act[d]);
        end else begin
          logic [8:0] e;
          e = exp_q[d].pop_front();
          check($sformatf("out_u%0d", d), {22'd0, act[d]}, {22'd0, 1'b1, e});
        end
      end
    end
  end

  logic [7:0] none[$];
  logic [7:0] fr[$];
  logic [7:0] e0[$];
  logic [7:0] e1[$];
  logic [7:0] e2[$];

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_row   = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state.
    check("rst_out_valid", out_valid0, 1'b0);
    check("rst_out_row", out_row0, 8'h00);
    check("rst_out_last", out_last0, 1'b0);
    check("rst_frame_count", fc0, 16'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready0, 1'b1);

    // Blinker: vertical bar becomes a horizontal one.
    fr = {8'h00, 8'h1C, 8'h00};
    e0 = {8'h08, 8'h08, 8'h08};
    run_frame(fr, e0, none, none, 0);
    drain_and_count("blinker");

    // Still-life block, then an immediate second blinker frame.
    fr = {8'h00, 8'h18, 8'h18, 8'h00};
    e0 = {8'h00, 8'h18, 8'h18, 8'h00};
    run_frame(fr, e0, none, none, 0);
    fr = {8'h00, 8'h1C, 8'h00};
    e0 = {8'h08, 8'h08, 8'h08};
    run_frame(fr, e0, none, none, 0);
    drain_and_count("block_blinker");

    // Single-row frame: edge cells die without wrap, survive with wrap.
    fr = {8'hFF};
    e0 = {8'h7E};
    e1 = {8'hFF};
    run_frame(fr, e0, e1, none, 0);
    drain_and_count("single_row");

    // HighLife birth: dead centre of row 1 has six live neighbours.
    fr = {8'h07, 8'h05, 8'h02};
    e0 = {8'h05, 8'h05, 8'h02};
    e2 = {8'h05, 8'h07, 8'h02};
    run_frame(fr, e0, none, e2, 0);
    drain_and_count("highlife");

    // Backpressure: hold out_ready low for 5 cycles after the first output.
    rdy_mode  = RDY_MANUAL;
    man_ready = 1'b1;
    fr = {8'h3C, 8'h66, 8'h18, 8'h81};
    fork
      run_frame(fr, none, none, none, 0);
      begin
        int budget;
        logic [7:0] held_row;
        logic       held_last;
        budget = 0;
        while (!out_valid0 && budget < 50) begin
          @(posedge clk);
          #1;
          budget++;
        end
        check("bp_first_output_seen", out_valid0, 1'b1);
        man_ready = 1'b0;
        held_row  = out_row0;
        held_last = out_last0;
        repeat (5) begin
          @(posedge clk);
          #1;
          check("bp_valid_held", out_valid0, 1'b1);
          check("bp_row_stable", out_row0, held_row);
          check("bp_last_stable", out_last0, held_last);
          check("bp_in_ready_low", in_ready0, 1'b0);
        end
        man_ready = 1'b1;
      end
    join
    drain_and_count("backpressure");

    // Reset mid-frame with an output row pending.
    man_ready = 1'b0;
    drive_row(8'h00, 1'b0);
    drive_row(8'h1C, 1'b0);
    check("mid_pre_reset_valid", out_valid0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_frames = 0;
    check("mid_rst_out_valid", out_valid0, 1'b0);
    check("mid_rst_in_ready", in_ready0, 1'b1);
    check("mid_rst_frame_count", fc0, 16'd0);
    rdy_mode = RDY_ALWAYS;
    fr = {8'h00, 8'h1C, 8'h00};
    e0 = {8'h08, 8'h08, 8'h08};
    run_frame(fr, e0, none, none, 0);
    drain_and_count("after_reset");

    // Random frames with random input gaps and output stalls.
    rdy_mode = RDY_RANDOM;
    for (int f = 0; f < 200; f++) begin
      int nrows;
      nrows = int'($urandom_range(1, 6));
      fr.delete();
      for (int r = 0; r < nrows; r++) fr.push_back(8'($urandom));
      run_frame(fr, none, none, none, 2);
    end
    rdy_mode = RDY_ALWAYS;
    drain_and_count("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
